// File: rtl/spi_reg_bank.sv
// Addressed SPI (mode 0) register bank: command byte {W/Rn, addr[6:0]}, then DW-bit data words with burst auto-increment.
// Define SPI_REG_BANK_READBACK_EN to drive register contents back on spi_miso for read commands.
module spi_reg_bank #(
  parameter int                 NREG    = 8,
  parameter int                 DW      = 8,
  parameter logic [NREG*DW-1:0] RST_VAL = '0
) (
  input  logic               spi_clk,
  input  logic               rst,
  input  logic               spi_csn,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic [NREG*DW-1:0] cfg_regs,
  output logic [NREG-1:0]    wr_strobe,
  output logic               frame_err
);

  localparam int             CW       = $clog2(DW);
  localparam logic [CW-1:0]  LAST_BIT = CW'(DW - 1);
  localparam logic [7:0]     NREG8    = 8'(NREG);

  typedef enum logic {CMD, DATA} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [CW-1:0]   data_cnt_reg, data_cnt_next;
  logic [6:0]      cmd_reg, cmd_next;
  logic [6:0]      addr_reg, addr_next;
  logic            wr_reg, wr_next;
  logic [DW-2:0]   rx_reg, rx_next;
  logic [7:0]      cmd_word;
  logic [DW-1:0]   rx_word;
  logic [NREG-1:0] addr_hit;
  logic [NREG-1:0] strobe_next;
  logic            addr_ok;
  logic            commit;
  logic            err_set;
  logic            err_clr;
  logic            frame_rst;

  // Dropping chip select aborts the frame but must not touch committed registers.
  assign frame_rst = rst | spi_csn;
  assign cmd_word  = {cmd_reg, spi_mosi};
  assign rx_word   = {rx_reg, spi_mosi};
  assign addr_ok   = {1'b0, addr_reg} < NREG8;

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_cnt_next = data_cnt_reg;
    cmd_next      = cmd_reg;
    addr_next     = addr_reg;
    wr_next       = wr_reg;
    rx_next       = rx_reg;
    commit        = 1'b0;
    err_set       = 1'b0;
    err_clr       = 1'b0;
    case (state_reg)
      CMD: begin
        cmd_next     = cmd_word[6:0];
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          state_next    = DATA;
          addr_next     = cmd_word[6:0];
          wr_next       = cmd_word[7];
          data_cnt_next = '0;
          err_clr       = 1'b1;
        end
      end
      DATA: begin
        rx_next       = rx_word[DW-2:0];
        data_cnt_next = data_cnt_reg + CW'(1);
        if (data_cnt_reg == LAST_BIT) begin
          data_cnt_next = '0;
          addr_next     = addr_reg + 7'd1;
          commit        = wr_reg && addr_ok;
          err_set       = !addr_ok;
        end
      end
      default: state_next = CMD;
    endcase
  end

  assign strobe_next = commit ? addr_hit : '0;

  always_ff @(posedge spi_clk or posedge frame_rst) begin
    if (frame_rst) begin
      state_reg    <= CMD;
      bit_cnt_reg  <= '0;
      data_cnt_reg <= '0;
      cmd_reg      <= '0;
      addr_reg     <= '0;
      wr_reg       <= 1'b0;
      rx_reg       <= '0;
      wr_strobe    <= '0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_cnt_reg <= data_cnt_next;
      cmd_reg      <= cmd_next;
      addr_reg     <= addr_next;
      wr_reg       <= wr_next;
      rx_reg       <= rx_next;
      wr_strobe    <= strobe_next;
    end
  end

  always_ff @(posedge spi_clk or posedge rst) begin
    if (rst)          frame_err <= 1'b0;
    else if (err_clr) frame_err <= 1'b0;
    else if (err_set) frame_err <= 1'b1;
  end

  // Each register loads only on a completed word, so outputs never see a partial shift.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [DW-1:0] value_reg;
      assign addr_hit[gi] = (addr_reg == 7'(gi));
      always_ff @(posedge spi_clk or posedge rst) begin
        if (rst)                  value_reg <= RST_VAL[gi*DW +: DW];
        else if (strobe_next[gi]) value_reg <= rx_word;
      end
      assign cfg_regs[gi*DW +: DW] = value_reg;
    end
  endgenerate

`ifdef SPI_REG_BANK_READBACK_EN
  logic [DW-1:0] tx_reg, tx_next, rd_word;
  logic [6:0]    rd_addr;

  // Load address is the decoded command address, or the next burst address at word end.
  assign rd_addr = (state_reg == CMD) ? cmd_word[6:0] : addr_reg + 7'd1;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_addr == 7'(i)) rd_word = cfg_regs[i*DW +: DW];
    end
  end

  always_comb begin
    tx_next = tx_reg;
    if (state_reg == CMD) begin
      if (bit_cnt_reg == 3'd7 && !cmd_word[7]) tx_next = rd_word;
    end else if (!wr_reg && data_cnt_reg == LAST_BIT) begin
      tx_next = rd_word;
    end else begin
      tx_next = {tx_reg[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge spi_clk or posedge frame_rst) begin
    if (frame_rst) tx_reg <= '0;
    else           tx_reg <= tx_next;
  end

  assign spi_miso = (state_reg == DATA) && !wr_reg && tx_reg[DW-1];
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed protocol cases plus random frames checked against a frame-level register model.
module tb_spi_reg_bank;

  localparam int          NREG = 8;
  localparam int          DW   = 8;
  localparam logic [63:0] RSTV = 64'hF0E1_D2C3_B4A5_9687;

  logic              spi_clk = 1'b0;
  logic              rst     = 1'b1;
  logic              spi_csn = 1'b1;
  logic              spi_mosi = 1'b0;
  logic              spi_miso;
  logic [NREG*DW-1:0] cfg_regs;
  logic [NREG-1:0]   wr_strobe;
  logic              frame_err;

  spi_reg_bank #(.NREG(NREG), .DW(DW), .RST_VAL(RSTV)) dut (
    .spi_clk  (spi_clk),
    .rst      (rst),
    .spi_csn  (spi_csn),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .cfg_regs (cfg_regs),
    .wr_strobe(wr_strobe),
    .frame_err(frame_err)
  );

  always #5 spi_clk = ~spi_clk;

  int          passed = 0;
  int          total  = 0;
  int          failed = 0;
  logic [7:0]  model [NREG];
  logic        model_err;
  logic [7:0]  fbuf [8];
  logic [63:0] rst_vals;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] packed_model();
    logic [63:0] r;
    for (int i = 0; i < NREG; i++) r[i*8 +: 8] = model[i];
    return r;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NREG; i++) model[i] = rst_vals[i*8 +: 8];
    model_err = 1'b0;
  endtask

  // Shift nbits of fbuf out MSB first, checking strobe and miso before every edge,
  // then apply the frame's effect to the model and compare registers and error flag.
  task automatic run_frame(input int nbits);
    logic [7:0] cmd;
    logic [6:0] a0, a;
    logic       wr, em;
    logic [7:0] es;
    int         e, k;
    cmd = fbuf[0];
    a0  = cmd[6:0];
    wr  = cmd[7];
    for (int j = 0; j <= nbits; j++) begin
      @(negedge spi_clk);
      es = '0;
      e  = j - 1;
      if (e >= 15 && (e - 15) % 8 == 0) begin
        k = (e - 15) / 8;
        a = a0 + 7'(k);
        if (wr && a < 7'd8) es[a[2:0]] = 1'b1;
      end
      em = 1'b0;
`ifdef SPI_REG_BANK_READBACK_EN
      if (!wr && j >= 8) begin
        k = (j - 8) / 8;
        a = a0 + 7'(k);
        if (a < 7'd8) em = model[a[2:0]][7 - (j - 8) % 8];
      end
`endif
      chk("strobe", wr_strobe, es);
      chk("miso", spi_miso, em);
      if (j < nbits) begin
        spi_csn  = 1'b0;
        spi_mosi = fbuf[j/8][7 - j%8];
      end
    end
    if (nbits >= 8) begin
      model_err = 1'b0;
      for (int w = 0; w < (nbits - 8) / 8; w++) begin
        a = a0 + 7'(w);
        if (a < 7'd8) begin
          if (wr) model[a[2:0]] = fbuf[w+1];
        end else begin
          model_err = 1'b1;
        end
      end
    end
    chk("cfg_regs", cfg_regs, packed_model());
    chk("frame_err", frame_err, model_err);
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    #1;
    chk("strobe_csn", wr_strobe, 8'h00);
    chk("miso_idle", spi_miso, 1'b0);
  endtask

  initial begin
    int nbits;
    rst_vals = RSTV;
    reset_model();

    // Reset state
    @(negedge spi_clk);
    @(negedge spi_clk);
    chk("rst_cfg", cfg_regs, rst_vals);
    chk("rst_strobe", wr_strobe, 8'h00);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_miso", spi_miso, 1'b0);
    rst = 1'b0;

    // Single write to reg2
    fbuf[0] = 8'h82; fbuf[1] = 8'hA5;
    run_frame(16);
    chk("reg2", cfg_regs[23:16], 8'hA5);

    // Aborted mid-word write, then a complete one
    fbuf[0] = 8'h83; fbuf[1] = 8'hF0;
    run_frame(12);
    fbuf[0] = 8'h83; fbuf[1] = 8'h5A;
    run_frame(16);
    chk("reg3", cfg_regs[31:24], 8'h5A);

    // Aborted mid-command, next frame starts a fresh command
    fbuf[0] = 8'h81;
    run_frame(5);
    fbuf[0] = 8'h84; fbuf[1] = 8'h99;
    run_frame(16);

    // Burst write then burst read of reg1/reg2
    fbuf[0] = 8'h81; fbuf[1] = 8'h3C; fbuf[2] = 8'hC3;
    run_frame(24);
    fbuf[0] = 8'h01; fbuf[1] = 8'h00; fbuf[2] = 8'h00;
    run_frame(24);

    // Burst running past the last register
    fbuf[0] = 8'h86; fbuf[1] = 8'h11; fbuf[2] = 8'h22; fbuf[3] = 8'h33;
    run_frame(32);
    chk("burst_err", frame_err, 1'b1);

    // Reset in the middle of a write to reg0
    fbuf[0] = 8'h80; fbuf[1] = 8'h5A;
    run_frame(16);
    fbuf[1] = 8'hFF;
    for (int j = 0; j < 11; j++) begin
      @(negedge spi_clk);
      spi_csn  = 1'b0;
      spi_mosi = fbuf[j/8][7 - j%8];
    end
    @(negedge spi_clk);
    rst = 1'b1;
    #1;
    reset_model();
    chk("midrst_cfg", cfg_regs, packed_model());
    chk("midrst_reg0", cfg_regs[7:0], rst_vals[7:0]);
    chk("midrst_strobe", wr_strobe, 8'h00);
    chk("midrst_err", frame_err, 1'b0);
    @(negedge spi_clk);
    rst      = 1'b0;
    spi_csn  = 1'b1;
    spi_mosi = 1'b0;
    fbuf[0] = 8'h81; fbuf[1] = 8'h77;
    run_frame(16);

    // Random frames, including wrap from address 127 to 0
    for (int n = 0; n < 40; n++) begin
      for (int b = 0; b < 8; b++) fbuf[b] = 8'($urandom);
      if ($urandom_range(0, 9) < 7) fbuf[0][6:0] = 7'($urandom_range(0, 11));
      else                          fbuf[0][6:0] = 7'($urandom_range(124, 127));
      nbits = 8 + 8 * $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) nbits = nbits + $urandom_range(1, 7);
      if ($urandom_range(0, 9) == 0) nbits = $urandom_range(1, 7);
      run_frame(nbits);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
